// File: rtl/l2_bank_router.sv
// Routes one TCDM-style master port onto word-interleaved plus contiguous private L2 banks,
// with an optional request register stage and a registered read/error response path.
module l2_bank_router #(
   parameter int unsigned           ADDR_WIDTH       = 32,
   parameter int unsigned           DATA_WIDTH       = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = 32'h1C00_0000,
   parameter int unsigned           N_L2_BANKS       = 4,
   parameter int unsigned           N_L2_BANKS_PRI   = 2,
   parameter int unsigned           L2_BANK_SIZE     = 28672,
   parameter int unsigned           L2_BANK_SIZE_PRI = 8192,
   parameter int unsigned           REQ_PIPE         = 0,
   localparam int unsigned          IL_AW            = $clog2(L2_BANK_SIZE),
   localparam int unsigned          PRI_AW           = $clog2(L2_BANK_SIZE_PRI),
   localparam int unsigned          BE_W             = DATA_WIDTH / 8
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               req_i,
   output logic                               gnt_o,
   input  logic [ADDR_WIDTH-1:0]              addr_i,
   input  logic                               we_i,
   input  logic [BE_W-1:0]                    be_i,
   input  logic [DATA_WIDTH-1:0]              wdata_i,
   output logic                               rvalid_o,
   output logic [DATA_WIDTH-1:0]              rdata_o,
   output logic                               err_o,
   output logic [N_L2_BANKS-1:0]              il_req_o,
   input  logic [N_L2_BANKS-1:0]              il_gnt_i,
   output logic [N_L2_BANKS*IL_AW-1:0]        il_addr_o,
   output logic [N_L2_BANKS_PRI-1:0]          pri_req_o,
   input  logic [N_L2_BANKS_PRI-1:0]          pri_gnt_i,
   output logic [N_L2_BANKS_PRI*PRI_AW-1:0]   pri_addr_o,
   output logic                               bank_we_o,
   output logic [BE_W-1:0]                    bank_be_o,
   output logic [DATA_WIDTH-1:0]              bank_wdata_o,
   input  logic [N_L2_BANKS*DATA_WIDTH-1:0]   il_rdata_i,
   input  logic [N_L2_BANKS_PRI*DATA_WIDTH-1:0] pri_rdata_i
);

   localparam int unsigned IL_SH  = $clog2(N_L2_BANKS);
   localparam int unsigned IL_BW  = (N_L2_BANKS > 1) ? IL_SH : 1;
   localparam int unsigned PRI_BW = (N_L2_BANKS_PRI > 1) ? $clog2(N_L2_BANKS_PRI) : 1;
   localparam int unsigned SEL_BW = (IL_BW > PRI_BW) ? IL_BW : PRI_BW;
   localparam logic [ADDR_WIDTH-1:0] PRI_WORDS = ADDR_WIDTH'(N_L2_BANKS_PRI * L2_BANK_SIZE_PRI);
   localparam logic [ADDR_WIDTH-1:0] IL_WORDS  = ADDR_WIDTH'(N_L2_BANKS * L2_BANK_SIZE);

   logic                  w_act_valid;
   logic [ADDR_WIDTH-1:0] w_act_addr;
   logic                  w_act_we;
   logic [BE_W-1:0]       w_act_be;
   logic [DATA_WIDTH-1:0] w_act_wdata;
   logic                  w_fire;

   generate
      if (REQ_PIPE == 0) begin : g_direct
         assign w_act_valid = req_i;
         assign w_act_addr  = addr_i;
         assign w_act_we    = we_i;
         assign w_act_be    = be_i;
         assign w_act_wdata = wdata_i;
         assign gnt_o       = req_i & w_fire;
      end else begin : g_pipe
         logic                  r_pipe_valid;
         logic [ADDR_WIDTH-1:0] r_pipe_addr;
         logic                  r_pipe_we;
         logic [BE_W-1:0]       r_pipe_be;
         logic [DATA_WIDTH-1:0] r_pipe_wdata;

         // A fire together with a new grant reloads the stage, so it never bubbles.
         assign gnt_o = req_i & (~r_pipe_valid | w_fire);

         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_pipe_valid <= 1'b0;
            end else if (gnt_o) begin
               r_pipe_valid <= 1'b1;
            end else if (w_fire) begin
               r_pipe_valid <= 1'b0;
            end
         end

         // NOTE: payload registers carry no reset; they are only observed behind a reset valid bit.
         always_ff @(posedge clk_i) begin
            if (gnt_o) begin
               r_pipe_addr  <= addr_i;
               r_pipe_we    <= we_i;
               r_pipe_be    <= be_i;
               r_pipe_wdata <= wdata_i;
            end
         end

         assign w_act_valid = r_pipe_valid;
         assign w_act_addr  = r_pipe_addr;
         assign w_act_we    = r_pipe_we;
         assign w_act_be    = r_pipe_be;
         assign w_act_wdata = r_pipe_wdata;
      end
   endgenerate

   logic                  w_below;
   logic [ADDR_WIDTH-1:0] w_off;
   logic [ADDR_WIDTH-1:0] w_word;
   logic [ADDR_WIDTH-1:0] w_iw;
   logic [ADDR_WIDTH-1:0] w_il_row_full;
   logic [ADDR_WIDTH-1:0] w_pri_bank_full;
   logic                  w_in_pri;
   logic                  w_in_il;
   logic                  w_err;
   logic [IL_BW-1:0]      w_il_bank;
   logic [IL_AW-1:0]      w_il_row;
   logic [PRI_BW-1:0]     w_pri_bank;
   logic [PRI_AW-1:0]     w_pri_row;
   logic                  w_bank_gnt;

   assign w_below  = (w_act_addr < BASE_ADDR);
   assign w_off    = w_act_addr - BASE_ADDR;
   assign w_word   = w_off >> 2;
   assign w_in_pri = ~w_below & (w_word < PRI_WORDS);
   assign w_iw     = w_word - PRI_WORDS;
   assign w_in_il  = ~w_below & ~w_in_pri & (w_iw < IL_WORDS);
   assign w_err    = ~w_in_pri & ~w_in_il;

   // Interleaved banks are a power of two, so modulo/divide reduce to slicing and shifting.
   assign w_il_bank       = (N_L2_BANKS > 1) ? w_iw[IL_BW-1:0] : '0;
   assign w_il_row_full   = w_iw >> IL_SH;
   assign w_il_row        = w_il_row_full[IL_AW-1:0];
   assign w_pri_bank_full = w_word >> PRI_AW;
   assign w_pri_bank      = (N_L2_BANKS_PRI > 1) ? w_pri_bank_full[PRI_BW-1:0] : '0;
   assign w_pri_row       = w_word[PRI_AW-1:0];

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      il_req_o  = '0;
      pri_req_o = '0;
      if (w_act_valid & w_in_il) begin
         il_req_o[w_il_bank] = 1'b1;
      end
      if (w_act_valid & w_in_pri) begin
         pri_req_o[w_pri_bank] = 1'b1;
      end
   end

   assign w_bank_gnt = w_err
                     | (w_in_il  & il_gnt_i[w_il_bank])
                     | (w_in_pri & pri_gnt_i[w_pri_bank]);
   assign w_fire     = w_act_valid & w_bank_gnt;

   generate
      for (genvar i = 0; i < N_L2_BANKS; i++) begin : g_il_addr
         assign il_addr_o[i*IL_AW +: IL_AW] = (w_act_valid & w_in_il) ? w_il_row : '0;
      end
      for (genvar j = 0; j < N_L2_BANKS_PRI; j++) begin : g_pri_addr
         assign pri_addr_o[j*PRI_AW +: PRI_AW] = (w_act_valid & w_in_pri) ? w_pri_row : '0;
      end
   endgenerate

   // Broadcast write bus stays quiet unless a real bank access is presented.
   assign bank_we_o    = w_act_valid & ~w_err & w_act_we;
   assign bank_be_o    = (w_act_valid & ~w_err) ? w_act_be    : '0;
   assign bank_wdata_o = (w_act_valid & ~w_err) ? w_act_wdata : '0;

   logic              r_resp_valid;
   logic              r_resp_err;
   logic              r_resp_pri;
   logic [SEL_BW-1:0] r_resp_bank;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
      end else begin
         r_resp_valid <= w_fire;
         r_resp_err   <= w_fire & w_err;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_fire) begin
         r_resp_pri  <= w_in_pri;
         r_resp_bank <= w_in_pri ? SEL_BW'(w_pri_bank) : SEL_BW'(w_il_bank);
      end
   end

   always_comb begin
      rdata_o = '0;
      if (r_resp_valid & ~r_resp_err) begin
         if (r_resp_pri) begin
            rdata_o = pri_rdata_i[r_resp_bank*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            rdata_o = il_rdata_i[r_resp_bank*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign rvalid_o = r_resp_valid;
   assign err_o    = r_resp_valid & r_resp_err;

endmodule
